// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the three buses around the shared-memory arbiter:
//   fetch side  : if_req, if_addr -> if_rdata, if_ack, if_err
//   data side   : d_req, d_we, d_addr, d_wdata -> d_rdata, d_ack, d_err
//   memory side : mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ready
// Modport master is the arbiter's view; modport slave is the view of the
// environment (core requesters plus memory) that surrounds it.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // Instruction-fetch requester
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;
  logic                  if_err;

  // Load/store requester
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ack;
  logic                  d_err;

  // Single-ported memory
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_ack, if_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_ack, if_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch and the
// load/store requesters of the core. One access is in flight at a time:
// IDLE picks a requester, MEM_I/MEM_D drive the memory from latched copies
// of the request, RESP pulses the owner's ack with its read data and error.
// Data has priority over fetch, except when fetch has already lost MAX_WAIT
// grants in a row. An access that sees no mem_ready for TIMEOUT cycles is
// terminated with err = 1 and rdata = 0.
// Ports:
//   clock  - rising-edge system clock
//   reset  - asynchronous, active-low; clears all state and outputs
//   bus    - mem_port_arbiter_if.master (fetch, data and memory buses)
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.master   bus
);

  localparam int SW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM_I = 2'd1,
    MEM_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [7:0]    tmo_cnt;
  logic          starve_full;
  logic          fetch_forced;
  logic          access_done;

  // Fetch has lost MAX_WAIT grants in a row and is still asking: it wins.
  assign starve_full  = (starve_cnt == SW'(MAX_WAIT));
  assign fetch_forced = bus.if_req && starve_full;

  // The access ends either with the memory's answer or with the watchdog.
  assign access_done  = bus.mem_ready || (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      tmo_cnt       <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.if_err    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.d_rdata   <= '0;
    end else begin
      // Acks are single-cycle pulses raised only on entry to RESP.
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;

      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (bus.d_req && !fetch_forced) begin
            state         <= MEM_D;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= ADDR_WIDTH'(bus.d_addr);
            bus.mem_wdata <= DATA_WIDTH'(bus.d_wdata);
            // Only a grant that overtakes a waiting fetch counts as starvation.
            if (bus.if_req && !starve_full) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (bus.if_req) begin
            state        <= MEM_I;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= ADDR_WIDTH'(bus.if_addr);
            starve_cnt   <= '0;
          end
        end

        MEM_I, MEM_D: begin
          if (access_done) begin
            state       <= RESP;
            tmo_cnt     <= '0;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            // mem_ready takes precedence over a watchdog expiring the same cycle.
            if (state == MEM_I) begin
              bus.if_ack   <= 1'b1;
              bus.if_err   <= !bus.mem_ready;
              bus.if_rdata <= bus.mem_ready ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
            end else begin
              bus.d_ack    <= 1'b1;
              bus.d_err    <= !bus.mem_ready;
              bus.d_rdata  <= bus.mem_ready ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        RESP: begin
          // Requesters drop req on this edge, so IDLE sees fresh requests only.
          state   <= IDLE;
          tmo_cnt <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 3;
  localparam int TIMEOUT  = 16;
  localparam int NRAND    = 3000;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_port_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MAX_WAIT  (MAX_WAIT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_if_ack;
    logic [31:0] e_if_rdata;
    logic        e_d_ack;
    logic [31:0] e_d_rdata;
    logic        e_err;
  } vec_t;

  vec_t tbl [19];

  // Reference memory for the random phase
  logic [31:0] mem_a [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t v(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
    input logic [31:0] da, input logic [31:0] dwd, input logic rdy, input logic [31:0] rdt,
    input logic mreq, input logic mwe, input logic [31:0] maddr, input logic [31:0] mwd,
    input logic iack, input logic [31:0] ird, input logic dack, input logic [31:0] drd,
    input logic err);
    vec_t r;
    r.if_req = ir;  r.if_addr = ia; r.d_req = dr; r.d_we = dwe;
    r.d_addr = da;  r.d_wdata = dwd; r.mem_ready = rdy; r.mem_rdata = rdt;
    r.e_mem_req = mreq; r.e_mem_we = mwe; r.e_mem_addr = maddr; r.e_mem_wdata = mwd;
    r.e_if_ack = iack; r.e_if_rdata = ird; r.e_d_ack = dack; r.e_d_rdata = drd;
    r.e_err = err;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd,
                       input logic rdy, input logic [31:0] rdt);
    bus.if_req    = ir;
    bus.if_addr   = ia;
    bus.d_req     = dr;
    bus.d_we      = dwe;
    bus.d_addr    = da;
    bus.d_wdata   = dwd;
    bus.mem_ready = rdy;
    bus.mem_rdata = rdt;
  endtask

  // Random-phase model state
  int          idle_at, mem_lo, mem_hi, ack_at, m_wait, m_starve, mlen, ng, early;
  logic        m_owner, m_we, m_to, in_mem, granted, prev_req, owner, done;
  logic [31:0] m_addr, m_wdata, m_val, e_if_rd, e_d_rd;
  logic        e_if_err, e_d_err;
  logic        r_if, r_d, r_d_we;
  logic [31:0] r_if_addr, r_d_addr, r_d_wdata;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //       ir ia      dr we da     dwd            rdy rdt           mreq we maddr   mwd           iack ird           dack drd          err
    tbl[0]  = v(1, 32'h4, 0, 0, 0,      0,             0, 0,            0, 0, 0,      0,            0, 0,            0, 0,            0);
    tbl[1]  = v(1, 32'h4, 0, 0, 0,      0,             1, 32'h20020005, 1, 0, 32'h4,  0,            0, 0,            0, 0,            0);
    tbl[2]  = v(0, 0,     0, 0, 0,      0,             0, 0,            0, 0, 0,      0,            1, 32'h20020005, 0, 0,            0);
    tbl[3]  = v(0, 0,     0, 0, 0,      0,             0, 0,            0, 0, 0,      0,            0, 32'h20020005, 0, 0,            0);
    tbl[4]  = v(0, 0,     1, 1, 32'h20, 32'hDEADBEEF,  0, 0,            0, 0, 0,      0,            0, 32'h20020005, 0, 0,            0);
    tbl[5]  = v(0, 0,     1, 1, 32'h20, 32'hDEADBEEF,  0, 0,            1, 1, 32'h20, 32'hDEADBEEF, 0, 32'h20020005, 0, 0,            0);
    tbl[6]  = v(0, 0,     1, 1, 32'h20, 32'hDEADBEEF,  0, 0,            1, 1, 32'h20, 32'hDEADBEEF, 0, 32'h20020005, 0, 0,            0);
    tbl[7]  = v(0, 0,     1, 1, 32'h20, 32'hDEADBEEF,  1, 32'h11112222, 1, 1, 32'h20, 32'hDEADBEEF, 0, 32'h20020005, 0, 0,            0);
    tbl[8]  = v(0, 0,     0, 0, 0,      0,             0, 0,            0, 0, 0,      0,            0, 32'h20020005, 1, 32'h11112222, 0);
    tbl[9]  = v(0, 0,     0, 0, 0,      0,             0, 0,            0, 0, 0,      0,            0, 32'h20020005, 0, 32'h11112222, 0);
    tbl[10] = v(1, 32'h8, 0, 0, 0,      0,             0, 0,            0, 0, 0,      0,            0, 32'h20020005, 0, 32'h11112222, 0);
    tbl[11] = v(1, 32'hC, 0, 0, 0,      0,             0, 0,            1, 0, 32'h8,  0,            0, 32'h20020005, 0, 32'h11112222, 0);
    tbl[12] = v(1, 32'hC, 1, 0, 32'h30, 0,             0, 0,            1, 0, 32'h8,  0,            0, 32'h20020005, 0, 32'h11112222, 0);
    tbl[13] = v(1, 32'hC, 1, 0, 32'h30, 0,             1, 32'h88,       1, 0, 32'h8,  0,            0, 32'h20020005, 0, 32'h11112222, 0);
    tbl[14] = v(0, 0,     1, 0, 32'h30, 0,             0, 0,            0, 0, 0,      0,            1, 32'h88,       0, 32'h11112222, 0);
    tbl[15] = v(0, 0,     1, 0, 32'h30, 0,             0, 0,            0, 0, 0,      0,            0, 32'h88,       0, 32'h11112222, 0);
    tbl[16] = v(0, 0,     1, 0, 32'h30, 0,             1, 32'h33,       1, 0, 32'h30, 0,            0, 32'h88,       0, 32'h11112222, 0);
    tbl[17] = v(0, 0,     0, 0, 0,      0,             0, 0,            0, 0, 0,      0,            0, 32'h88,       1, 32'h33,       0);
    tbl[18] = v(0, 0,     0, 0, 0,      0,             0, 0,            0, 0, 0,      0,            0, 32'h88,       0, 32'h33,       0);

    // Reset values
    tick();
    tick();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_if_ack", bus.if_ack, 0);
    chk("rst_d_ack", bus.d_ack, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    reset = 1'b1;

    // Directed vectors: single fetch, store with wait states, input stability
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("v%0d_mem_req", i), bus.mem_req, tbl[i].e_mem_req);
      chk($sformatf("v%0d_mem_we", i), bus.mem_we, tbl[i].e_mem_we);
      if (tbl[i].e_mem_req) chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, tbl[i].e_mem_addr);
      if (tbl[i].e_mem_we) chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, tbl[i].e_mem_wdata);
      chk($sformatf("v%0d_if_ack", i), bus.if_ack, tbl[i].e_if_ack);
      chk($sformatf("v%0d_if_rdata", i), bus.if_rdata, tbl[i].e_if_rdata);
      chk($sformatf("v%0d_d_ack", i), bus.d_ack, tbl[i].e_d_ack);
      chk($sformatf("v%0d_d_rdata", i), bus.d_rdata, tbl[i].e_d_rdata);
      if (tbl[i].e_if_ack) chk($sformatf("v%0d_if_err", i), bus.if_err, tbl[i].e_err);
      if (tbl[i].e_d_ack) chk($sformatf("v%0d_d_err", i), bus.d_err, tbl[i].e_err);
      drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].d_req, tbl[i].d_we, tbl[i].d_addr,
            tbl[i].d_wdata, tbl[i].mem_ready, tbl[i].mem_rdata);
      tick();
    end

    // Reset in the middle of a stalled store
    drive(0, 0, 1, 1, 32'h50, 32'hABCD, 0, 0);
    tick();
    tick();
    chk("mid_mem_req", bus.mem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_mem_req", bus.mem_req, 0);
    chk("arst_mem_we", bus.mem_we, 0);
    chk("arst_mem_addr", bus.mem_addr, 0);
    chk("arst_mem_wdata", bus.mem_wdata, 0);
    chk("arst_acks", {bus.if_ack, bus.d_ack}, 0);
    chk("arst_errs", {bus.if_err, bus.d_err}, 0);
    chk("arst_if_rdata", bus.if_rdata, 0);
    chk("arst_d_rdata", bus.d_rdata, 0);
    @(negedge clock);
    reset = 1'b1;
    drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
    tick();
    chk("post_rst_mem_req", bus.mem_req, 1);
    chk("post_rst_mem_addr", bus.mem_addr, 32'h10);
    chk("post_rst_mem_we", bus.mem_we, 0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1234;
    tick();
    chk("post_rst_if_ack", bus.if_ack, 1);
    chk("post_rst_no_d_ack", bus.d_ack, 0);
    chk("post_rst_if_rdata", bus.if_rdata, 32'h1234);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Starvation: both requesters always asking, zero-wait memory
    drive(1, 32'h100, 1, 0, 32'h200, 0, 1, 32'h5555);
    ng = 0;
    prev_req = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      if (bus.mem_req && !prev_req) begin
        owner = (bus.mem_addr == 32'h200);
        chk($sformatf("starve_grant%0d", ng), owner, (ng % 4 == 3) ? 1'b0 : 1'b1);
        ng++;
      end
      prev_req = bus.mem_req;
      bus.d_req  = (ng >= 12) ? 1'b0 : !bus.d_ack;
      bus.if_req = !bus.if_ack;
      if (ng >= 12 && bus.if_ack) begin
        bus.if_req = 1'b0;
        done = 1'b1;
      end
    end
    chk("starve_grant_count", ng, 12);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Watchdog on a load that never gets mem_ready
    drive(0, 0, 1, 0, 32'h40, 0, 0, 0);
    early = 0;
    for (int n = 1; n <= TIMEOUT + 1; n++) begin
      tick();
      if (n <= TIMEOUT && bus.d_ack) early++;
      if (n == TIMEOUT) chk("tmo_mem_req_last", bus.mem_req, 1);
    end
    chk("tmo_early_acks", early, 0);
    chk("tmo_d_ack", bus.d_ack, 1);
    chk("tmo_d_err", bus.d_err, 1);
    chk("tmo_d_rdata", bus.d_rdata, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 32'h44, 0, 0, 0, 0, 1, 32'h77);
    tick();
    tick();
    chk("after_tmo_if_ack", bus.if_ack, 1);
    chk("after_tmo_if_err", bus.if_err, 0);
    chk("after_tmo_if_rdata", bus.if_rdata, 32'h77);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Random traffic against a transaction-timeline model
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle_at = 0; mem_lo = -1; mem_hi = -2; ack_at = -1; m_wait = 0; m_starve = 0;
    m_owner = 0; m_we = 0; m_to = 0; m_addr = 0; m_wdata = 0; m_val = 0;
    e_if_rd = 0; e_d_rd = 0; e_if_err = 0; e_d_err = 0;
    r_if = 0; r_d = 0; r_d_we = 0; r_if_addr = 0; r_d_addr = 0; r_d_wdata = 0;
    for (int k = 0; k < NRAND; k++) begin
      in_mem = (k >= mem_lo) && (k <= mem_hi);
      if (k == ack_at) begin
        if (m_owner) begin e_d_rd = m_to ? 32'h0 : m_val; e_d_err = m_to; end
        else begin e_if_rd = m_to ? 32'h0 : m_val; e_if_err = m_to; end
      end
      chk("r_mem_req", bus.mem_req, in_mem);
      chk("r_mem_we", bus.mem_we, in_mem && m_owner && m_we);
      if (in_mem) chk("r_mem_addr", bus.mem_addr, m_addr);
      if (in_mem && m_owner && m_we) chk("r_mem_wdata", bus.mem_wdata, m_wdata);
      chk("r_if_ack", bus.if_ack, (k == ack_at) && !m_owner);
      chk("r_d_ack", bus.d_ack, (k == ack_at) && m_owner);
      chk("r_if_rdata", bus.if_rdata, e_if_rd);
      chk("r_d_rdata", bus.d_rdata, e_d_rd);
      if (k == ack_at && !m_owner) chk("r_if_err", bus.if_err, e_if_err);
      if (k == ack_at && m_owner) chk("r_d_err", bus.d_err, e_d_err);

      // Requesters: drop on the ack cycle, otherwise occasionally issue a new request
      if (k == ack_at && !m_owner) r_if = 1'b0;
      else if (!r_if && $urandom_range(0, 2) == 0) begin
        r_if = 1'b1;
        r_if_addr = 32'h2000 + ($urandom_range(0, 15) << 2);
      end
      if (k == ack_at && m_owner) r_d = 1'b0;
      else if (!r_d && $urandom_range(0, 2) == 0) begin
        r_d = 1'b1;
        r_d_we = $urandom_range(0, 1);
        r_d_addr = 32'h2000 + ($urandom_range(0, 15) << 2);
        r_d_wdata = $urandom;
      end

      // Memory: answers after the chosen wait, noise outside accesses
      if (in_mem && !m_to && k == mem_lo + m_wait) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = m_val;
      end else if (in_mem) begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end else begin
        bus.mem_ready = $urandom_range(0, 1);
        bus.mem_rdata = $urandom;
      end

      // Arbitration decision on cycles where the arbiter is free
      if (k == idle_at) begin
        granted = 1'b0;
        if (r_d && !(r_if && m_starve == MAX_WAIT)) begin
          m_owner = 1'b1; m_addr = r_d_addr; m_we = r_d_we; m_wdata = r_d_wdata;
          if (r_if) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
          granted = 1'b1;
        end else if (r_if) begin
          m_owner = 1'b0; m_addr = r_if_addr; m_we = 1'b0; m_starve = 0;
          granted = 1'b1;
        end
        if (granted) begin
          m_to   = ($urandom_range(0, 19) == 0);
          m_wait = $urandom_range(0, 3);
          mlen   = m_to ? TIMEOUT : m_wait + 1;
          mem_lo = k + 1;
          mem_hi = k + mlen;
          ack_at = k + 1 + mlen;
          idle_at = ack_at + 1;
          if (m_owner && m_we) begin
            m_val = $urandom;
            if (!m_to) mem_a[m_addr] = m_wdata;
          end else begin
            m_val = rd(m_addr);
          end
        end else begin
          idle_at = k + 1;
        end
      end

      bus.if_req  = r_if;
      bus.if_addr = r_if_addr;
      bus.d_req   = r_d;
      bus.d_we    = r_d_we;
      bus.d_addr  = r_d_addr;
      bus.d_wdata = r_d_wdata;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
